lsu_split_access: RTL
=====================

LSU_SPLIT_ACCESS -- requirements
Module: lsu_split_access

Interface
REQ-001 SHALL have parameters DATA_W (32; 32 or 64), ADDR_W (32), SPLIT_EN (1; 1 = split line-crossing accesses in hardware, 0 = trap), TIMEOUT (255; response-wait limit in cycles, 0 disables).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from EX.
- req_write  in  1  1 = store, 0 = load.
- req_len  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_sign  in  1  sign-extend load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- busy  out  1  pipeline stall.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data.
- rsp_err  out  1  bus error, timeout or illegal length.
- rsp_misaligned  out  1  crossing access rejected.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  lane-aligned address.
- bus_wdata  out  DATA_W  lane-positioned write data.
- bus_wmask  out  DATA_W/8  byte enables.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data / write ack.
- bus_rdata  in  DATA_W  read data.
- bus_err  in  1  error, qualified by bus_rvalid.

Function
REQ-003 SHALL use NB = DATA_W/8, off = req_addr mod NB, size = 2^req_len bytes, crossing = off+size > NB.
REQ-004 SHALL implement FSM IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
REQ-005 In IDLE with req_valid: SHALL register the request and move to ISSUE0, or directly to RESP with the matching flag if req_len=3 with DATA_W=32 (rsp_err) or crossing with SPLIT_EN=0 (rsp_misaligned); no bus traffic in either case.
REQ-006 Misaligned non-crossing accesses SHALL complete in one beat with no flag.
REQ-007 ISSUE0/ISSUE1 SHALL hold bus_req=1 and all bus outputs stable until bus_gnt, then go to WAIT0/WAIT1.
REQ-008 Beat 0: bus_addr = addr with low log2(NB) bits cleared; bus_wmask = bytes off..min(off+size,NB)-1; bus_wdata = wdata << 8*off.
REQ-009 Beat 1 (crossing only): bus_addr = beat-0 address + NB; bus_wmask = bytes 0..off+size-NB-1; bus_wdata = wdata >> 8*(NB-off).
REQ-010 WAIT0 on bus_rvalid: error -> RESP with rsp_err, beat 1 not issued; else -> ISSUE1 if crossing, otherwise RESP. WAIT1 on bus_rvalid -> RESP.
REQ-011 Stores SHALL also wait for bus_rvalid as write acknowledge.
REQ-012 Load data SHALL be (rdata0 >> 8*off) | (rdata1 << 8*(NB-off)), truncated to size, then sign- or zero-extended per req_sign.
REQ-013 A cycle counter SHALL clear on entry to each WAIT state; if TIMEOUT != 0 and it reaches TIMEOUT with no bus_rvalid -> RESP with rsp_err.
REQ-014 RESP SHALL pulse rsp_valid for exactly one cycle with rsp_rdata and flags valid, then return to IDLE. rsp_rdata SHALL be 0 for stores and errors.
REQ-015 busy SHALL equal (state != IDLE) && (state != RESP). req_valid in non-IDLE states SHALL be ignored.
REQ-016 bus_rvalid outside WAIT0/WAIT1 SHALL be ignored.
REQ-017 Minimum latency, zero-wait bus: acceptance edge N, bus_req in cycle N+1, rsp_valid in cycle N+3 (single beat) or N+5 (split).

Reset
REQ-018 Reset SHALL force IDLE asynchronously, clear the counter and registered request, and drive bus_req, busy, rsp_valid, rsp_err and rsp_misaligned to 0, and bus_addr, bus_wdata, bus_wmask and rsp_rdata to 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction; a late bus_rvalid SHALL be ignored.

Structure
REQ-020 Shared package SHALL hold the FSM state encoding, req_len codes and the sign/zero-extension function.
REQ-021 SHALL instantiate one sub-module, lsu_lane_align, combinational: shift/mask/extend for both beats.

Verification (DATA_W=32, zero-wait bus unless stated)
REQ-022 SW 0xDEADBEEF to 0x100 -> one beat: bus_addr 0x100, wmask 0xF, wdata 0xDEADBEEF; rsp_valid at N+3.
REQ-023 LH signed from 0x202, rdata 0x8001_0000 -> rsp_rdata 0xFFFF8001; same access unsigned -> 0x00008001.
REQ-024 LW from 0x103, rdata0 0x44xxxxxx, rdata1 0xxx332211 -> beats at 0x100 (mask 1000) and 0x104 (mask 0111); rsp_rdata 0x33221144; rsp_valid at N+5.
REQ-025 SPLIT_EN=0, LW 0x103 -> no bus_req; rsp_valid and rsp_misaligned at N+1. LD with DATA_W=32 -> rsp_err, no bus_req.
REQ-026 Split SW 0x103 with bus_err on beat 0 -> rsp_err, no second bus_req. TIMEOUT=4 with no bus_rvalid -> rsp_err after 4 WAIT cycles.
REQ-027 Reset asserted in WAIT0 -> bus_req and busy 0 immediately; bus_rvalid one cycle later produces no rsp_valid.

Source files
------------

// File: rtl/lsu_split_access_pkg.sv
// Shared types and helpers for the split-access load/store unit.
package lsu_split_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2,
    LEN_D = 2'd3
  } len_e;

  // True when an access of 2^len bytes starting at byte offset off runs past an nb-byte lane.
  function automatic logic crosses(input logic [3:0] off, input len_e len, input int nb);
    return (int'(off) + (1 << len)) > nb;
  endfunction

  // Truncate to the access size, then sign- or zero-extend back to 64 bits.
  function automatic logic [63:0] extend_load(input logic [63:0] d, input len_e len,
                                              input logic sgn);
    logic [63:0] r;
    r = d;
    case (len)
      LEN_B:   r = {{56{sgn & d[7]}}, d[7:0]};
      LEN_H:   r = {{48{sgn & d[15]}}, d[15:0]};
      LEN_W:   r = {{32{sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_split_access_if.sv
// Request/response and memory-bus signals of the load/store unit.
interface lsu_split_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_len;
  logic                  req_sign;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  busy;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_misaligned;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wmask;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_err;

  // The LSU itself: takes requests from EX and masters the memory bus.
  modport slave (
    input  req_valid, req_write, req_len, req_sign, req_addr, req_wdata,
    output busy, rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  // The environment: pipeline request side plus memory responder.
  modport master (
    output req_valid, req_write, req_len, req_sign, req_addr, req_wdata,
    input  busy, rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_split_access_lane_align.sv
// Combinational lane alignment: byte masks and write data for both beats, load merge and extension.
module lsu_lane_align
  import lsu_split_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  len_e                        len,
  input  logic                        sign,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata0,
  input  logic [DATA_W-1:0]           rdata1,
  output logic [DATA_W/8-1:0]         mask0,
  output logic [DATA_W/8-1:0]         mask1,
  output logic [DATA_W-1:0]           wdata0,
  output logic [DATA_W-1:0]           wdata1,
  output logic [DATA_W-1:0]           rdata_ext
);
  localparam int NB = DATA_W / 8;

  logic [2*NB-1:0]     size_m;
  logic [2*NB-1:0]     lane_m;
  logic [2*DATA_W-1:0] wd_sh;

  // Shift the access across a double-width window; the upper half is what spills into beat 1.
  always_comb begin
    size_m    = ((2*NB)'(1) << (32'd1 << len)) - (2*NB)'(1);
    lane_m    = size_m << off;
    wd_sh     = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    rdata_ext = DATA_W'(extend_load(64'(DATA_W'({rdata1, rdata0} >> {off, 3'b000})), len, sign));
  end

  assign mask0  = lane_m[NB-1:0];
  assign mask1  = lane_m[2*NB-1:NB];
  assign wdata0 = wd_sh[DATA_W-1:0];
  assign wdata1 = wd_sh[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/lsu_split_access.sv
// Load/store unit that splits lane-crossing accesses into two bus beats (or traps them).
module lsu_split_access
  import lsu_split_access_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SPLIT_EN = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  lsu_split_access_if.slave io
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  len_e              len_q, len_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic [NB-1:0]     mask0, mask1;
  logic [DATA_W-1:0] wdata0, wdata1, rdata_ext;
  logic              cross_req, cross_q, issuing, beat1, in_resp, timed_out;

  assign cross_req = crosses(4'(io.req_addr[OFF_W-1:0]), len_e'(io.req_len), NB);
  assign cross_q   = crosses(4'(addr_q[OFF_W-1:0]), len_q, NB);
  assign timed_out = (TIMEOUT != 0) && (({1'b0, cnt_q} + 1'b1) == (CNT_W+1)'(TIMEOUT));

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .off       (addr_q[OFF_W-1:0]),
    .len       (len_q),
    .sign      (sign_q),
    .wdata     (wdata_q),
    .rdata0    (rdata0_q),
    .rdata1    (rdata1_q),
    .mask0     (mask0),
    .mask1     (mask1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rdata_ext (rdata_ext)
  );

  // State, wait counter and the registered request; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      len_q    <= LEN_B;
      sign_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      len_q    <= len_d;
      sign_q   <= sign_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  // Next state: accept or trap in IDLE, issue/wait per beat, then a single RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    len_d    = len_q;
    sign_d   = sign_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    mis_d    = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (io.req_valid) begin
          write_d  = io.req_write;
          len_d    = len_e'(io.req_len);
          sign_d   = io.req_sign;
          addr_d   = io.req_addr;
          wdata_d  = io.req_wdata;
          rdata0_d = '0;
          rdata1_d = '0;
          err_d    = 1'b0;
          mis_d    = 1'b0;
          cnt_d    = '0;
          if (len_e'(io.req_len) == LEN_D && DATA_W == 32) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cross_req && SPLIT_EN == 0) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE0;
          end
        end
      end
      ST_ISSUE0: begin
        if (io.bus_gnt) begin
          cnt_d   = '0;
          state_d = ST_WAIT0;
        end
      end
      ST_WAIT0: begin
        if (io.bus_rvalid) begin
          rdata0_d = io.bus_rdata;
          if (io.bus_err) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cross_q) begin
            state_d = ST_ISSUE1;
          end else begin
            state_d = ST_RESP;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE1: begin
        if (io.bus_gnt) begin
          cnt_d   = '0;
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (io.bus_rvalid) begin
          rdata1_d = io.bus_rdata;
          err_d    = io.bus_err;
          state_d  = ST_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are driven only while a beat is being offered, so they sit at zero otherwise.
  assign issuing      = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
  assign beat1        = (state_q == ST_ISSUE1);
  assign in_resp      = (state_q == ST_RESP);
  assign io.bus_req   = issuing;
  assign io.bus_we    = issuing & write_q;
  assign io.bus_addr  = issuing ? ({addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} +
                                   (beat1 ? ADDR_W'(NB) : '0)) : '0;
  assign io.bus_wmask = issuing ? (beat1 ? mask1 : mask0) : '0;
  assign io.bus_wdata = issuing ? (beat1 ? wdata1 : wdata0) : '0;

  assign io.busy           = (state_q != ST_IDLE) && (state_q != ST_RESP);
  assign io.rsp_valid      = in_resp;
  assign io.rsp_err        = in_resp & err_q;
  assign io.rsp_misaligned = in_resp & mis_q;
  assign io.rsp_rdata      = (in_resp && !write_q && !err_q && !mis_q) ? rdata_ext : '0;

endmodule
